// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared constants, region decode and status packing
package data_mem_responder_pkg;

    localparam int DATA_W             = 32;
    localparam int RAM_WORDS_DEFAULT  = 64;
    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Memory-mapped register addresses (byte addresses, low two bits ignored)
    localparam logic [31:0] ADDR_LED       = 32'h8000_0000;
    localparam logic [31:0] ADDR_CYCLE     = 32'h8000_0004;
    localparam logic [31:0] ADDR_OUT       = 32'h8000_0008;
    localparam logic [31:0] ADDR_STATUS    = 32'h8000_000C;
    localparam logic [31:0] ADDR_WORD_MASK = 32'hFFFF_FFFC;

    // STATUS register bit layout
    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_COUNT_LSB = 2;
    localparam int STATUS_COUNT_W   = 3;
    localparam int STATUS_OVF_BIT   = 8;

    typedef enum logic [2:0] {
        REGION_RAM,
        REGION_LED,
        REGION_CYCLE,
        REGION_OUT,
        REGION_STATUS,
        REGION_NONE
    } region_e;

    function automatic region_e decode_region(input logic [31:0] addr);
        logic [31:0] word;
        word = addr & ADDR_WORD_MASK;
        if (word[31:8] == 24'd0)        return REGION_RAM;
        else if (word == ADDR_LED)      return REGION_LED;
        else if (word == ADDR_CYCLE)    return REGION_CYCLE;
        else if (word == ADDR_OUT)      return REGION_OUT;
        else if (word == ADDR_STATUS)   return REGION_STATUS;
        else                            return REGION_NONE;
    endfunction

    function automatic logic [31:0] make_status(
        input logic                      empty,
        input logic                      full,
        input logic [STATUS_COUNT_W-1:0] count,
        input logic                      overflow
    );
        logic [31:0] s;
        s = '0;
        s[STATUS_EMPTY_BIT]                      = empty;
        s[STATUS_FULL_BIT]                       = full;
        s[STATUS_COUNT_LSB +: STATUS_COUNT_W]    = count;
        s[STATUS_OVF_BIT]                        = overflow;
        return s;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - processor data bus and output stream bundle
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic              MemWrite;
    logic [DATA_W-1:0] Addr;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic [7:0]        leds;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output MemWrite, Addr, WriteData, out_ready,
        input  ReadData, leds, out_data, out_valid
    );

    modport slave (
        input  MemWrite, Addr, WriteData, out_ready,
        output ReadData, leds, out_data, out_valid
    );

endinterface

// File: rtl/data_mem_responder_out_fifo.sv
// rtl/data_mem_responder_out_fifo.sv - output word FIFO with same-cycle push/pop when full
module out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push_ok;
    logic             pop_ok;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // A pop frees a slot in the same edge, so a full FIFO still takes a push then
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNT_FULL);
        pop_ok    = pop && !empty;
        push_ok   = push && (!full || pop_ok);
        count     = count_q;
        head_data = empty ? '0 : mem[rd_ptr];
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data RAM plus LED, cycle counter and output FIFO registers
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int RAM_WORDS  = RAM_WORDS_DEFAULT,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    region_e          region;
    logic [5:0]       ram_idx;
    logic             ram_hit;
    logic [31:0]      ram_rdata;
    logic [31:0]      ram [0:RAM_WORDS-1];

    logic [7:0]       leds_q;
    logic [31:0]      cycle_q;
    logic             overflow_q;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [CNT_W-1:0] fifo_count;
    logic [31:0]      fifo_head;
    logic [2:0]       status_count;

    // Address decode and per-target write strobes
    always_comb begin
        region       = decode_region(bus.Addr);
        ram_idx      = bus.Addr[7:2];
        ram_hit      = (region == REGION_RAM) && (int'(ram_idx) < RAM_WORDS);
        ram_rdata    = ram_hit ? ram[ram_idx] : '0;
        fifo_push    = bus.MemWrite && (region == REGION_OUT);
        fifo_pop     = !fifo_empty && bus.out_ready;
        fifo_drop    = fifo_push && fifo_full && !fifo_pop;
        status_count = 3'(fifo_count);
    end

    // Data RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!reset && bus.MemWrite && ram_hit) ram[ram_idx] <= bus.WriteData;
    end

    // LED register, free-running cycle counter and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q     <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (bus.MemWrite && region == REGION_LED) leds_q <= bus.WriteData[7:0];
            if (fifo_drop) begin
                overflow_q <= 1'b1;
            end else if (bus.MemWrite && region == REGION_STATUS && bus.WriteData[STATUS_OVF_BIT]) begin
                overflow_q <= 1'b0;
            end
        end
    end

    out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (bus.WriteData),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head_data (fifo_head)
    );

    // Combinational load data mux and stream outputs
    always_comb begin
        bus.ReadData = '0;
        case (region)
            REGION_RAM:    bus.ReadData = ram_rdata;
            REGION_LED:    bus.ReadData = {24'd0, leds_q};
            REGION_CYCLE:  bus.ReadData = cycle_q;
            REGION_OUT:    bus.ReadData = '0;
            REGION_STATUS: bus.ReadData = make_status(fifo_empty, fifo_full, status_count, overflow_q);
            default:       bus.ReadData = '0;
        endcase
        bus.leds      = leds_q;
        bus.out_valid = !fifo_empty;
        bus.out_data  = fifo_head;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized and directed bench against a queue-based reference model
module tb_data_mem_responder;

    localparam int DEPTH = 4;
    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0004;
    localparam logic [31:0] A_OUT    = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;
    localparam logic [31:0] A_IDLE   = 32'h4000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(
        .RAM_WORDS  (64),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] m_ram [64];
    bit          m_known [64];
    logic [7:0]  m_leds;
    logic [31:0] m_cyc;
    logic [31:0] q [$];
    logic        m_ovf;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rd;
    logic [31:0] last_od;
    logic        last_ov;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_leds = 8'd0;
        m_cyc  = 32'd0;
        q.delete();
        m_ovf  = 1'b0;
    endtask

    // One bus cycle: drive at negedge, check combinational view, advance model on the edge
    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic rdy, input logic rst);
        logic [31:0] exp_rd;
        bit          skip;
        bit          full_pre;
        bit          do_pop;
        int          idx;
        logic [31:0] word;
        bus.MemWrite  = we;
        bus.Addr      = addr;
        bus.WriteData = wd;
        bus.out_ready = rdy;
        reset         = rst;
        #1;
        last_rd = bus.ReadData;
        last_od = bus.out_data;
        last_ov = bus.out_valid;
        skip    = 0;
        exp_rd  = 32'd0;
        word    = addr & 32'hFFFF_FFFC;
        idx     = int'(addr[7:2]);
        if (addr[31:8] == 24'd0) begin
            if (m_known[idx]) exp_rd = m_ram[idx];
            else skip = 1;
        end else if (word == A_LED) begin
            exp_rd = {24'd0, m_leds};
        end else if (word == A_CYCLE) begin
            exp_rd = m_cyc;
        end else if (word == A_STATUS) begin
            exp_rd = {23'd0, m_ovf, 3'd0, 3'(q.size()), 1'(q.size() == DEPTH), 1'(q.size() == 0)};
        end
        if (!skip) check("rdata", last_rd, exp_rd);
        check("out_valid", 32'(last_ov), 32'(q.size() != 0));
        check("out_data", last_od, (q.size() != 0) ? q[0] : 32'd0);
        check("leds", 32'(bus.leds), 32'(m_leds));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_cyc    = m_cyc + 32'd1;
            full_pre = (q.size() == DEPTH);
            do_pop   = (q.size() != 0) && rdy;
            if (do_pop) void'(q.pop_front());
            if (we) begin
                if (addr[31:8] == 24'd0) begin
                    m_ram[idx]   = wd;
                    m_known[idx] = 1;
                end else if (word == A_LED) begin
                    m_leds = wd[7:0];
                end else if (word == A_OUT) begin
                    if (!full_pre || do_pop) q.push_back(wd);
                    else m_ovf = 1'b1;
                end else if (word == A_STATUS) begin
                    if (wd[8]) m_ovf = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] w14;
        logic [31:0] raddr;
        int          r;

        bus.MemWrite  = 1'b0;
        bus.Addr      = 32'd0;
        bus.WriteData = 32'd0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        for (int i = 0; i < 64; i++) m_known[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state
        step(0, A_STATUS, 32'd0, 0, 1);
        check("rst_status", last_rd, 32'h0000_0001);
        step(0, A_LED, 32'd0, 0, 0);
        check("rst_leds", last_rd, 32'd0);

        // Fill RAM so every word has a known value
        for (int i = 0; i < 64; i++) step(1, 32'(i * 4), $urandom, 0, 0);

        // RAM store then load
        w14 = m_ram[5];
        step(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0);
        step(0, 32'h0000_0010, 32'd0, 0, 0);
        check("ram_rd", last_rd, 32'hDEAD_BEEF);
        step(0, 32'h0000_0017, 32'd0, 0, 0);
        check("ram_neighbour", last_rd, w14);

        // LED register
        step(1, A_LED, 32'h0000_01A5, 0, 0);
        check("led_port", 32'(bus.leds), 32'h0000_00A5);
        step(0, A_LED, 32'd0, 0, 0);
        check("led_rd", last_rd, 32'h0000_00A5);

        // Cycle counter from reset and wrap
        step(0, A_IDLE, 32'd0, 0, 1);
        repeat (10) step(0, A_IDLE, 32'd0, 0, 0);
        step(1, A_CYCLE, 32'h1234_5678, 0, 0);
        check("cycle_10", last_rd, 32'd10);
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        m_cyc = 32'hFFFF_FFFF;
        step(0, A_CYCLE, 32'd0, 0, 0);
        check("cycle_max", last_rd, 32'hFFFF_FFFF);
        step(0, A_CYCLE, 32'd0, 0, 0);
        check("cycle_wrap", last_rd, 32'd0);

        // Overflow on fifth push, then drain
        step(0, A_IDLE, 32'd0, 0, 1);
        for (int k = 1; k <= 5; k++) step(1, A_OUT, 32'(k), 0, 0);
        step(0, A_STATUS, 32'd0, 0, 0);
        check("status_ovf", last_rd, 32'h0000_0112);
        for (int k = 1; k <= 4; k++) begin
            step(0, A_IDLE, 32'd0, 1, 0);
            check("drain_head", last_od, 32'(k));
        end
        step(0, A_IDLE, 32'd0, 1, 0);
        check("drain_empty", 32'(last_ov), 32'd0);

        // Push and pop together while full, then clear overflow
        for (int k = 5; k <= 8; k++) step(1, A_OUT, 32'(k), 0, 0);
        step(1, A_OUT, 32'd9, 1, 0);
        check("full_pop_head", last_od, 32'd5);
        step(0, A_STATUS, 32'd0, 0, 0);
        check("full_pushpop_status", last_rd, 32'h0000_0112);
        step(1, A_STATUS, 32'h0000_0100, 0, 0);
        step(0, A_STATUS, 32'd0, 0, 0);
        check("ovf_cleared", last_rd, 32'h0000_0012);
        for (int k = 6; k <= 9; k++) begin
            step(0, A_IDLE, 32'd0, 1, 0);
            check("drain2_head", last_od, 32'(k));
        end

        // Push into empty with out_ready high must not pop
        step(1, A_OUT, 32'h0000_0077, 1, 0);
        step(0, A_STATUS, 32'd0, 0, 0);
        check("empty_push_status", last_rd, 32'h0000_0004);
        check("empty_push_head", last_od, 32'h0000_0077);
        step(0, A_IDLE, 32'd0, 1, 0);

        // Reset mid-stream
        step(1, A_OUT, 32'h0000_000A, 0, 0);
        step(1, A_OUT, 32'h0000_000B, 0, 0);
        step(1, A_OUT, 32'h0000_000C, 1, 1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        step(0, A_STATUS, 32'd0, 0, 0);
        check("rst_mid_status", last_rd, 32'h0000_0001);
        step(0, 32'h0000_0010, 32'd0, 0, 0);
        check("ram_survives", last_rd, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: raddr = {24'd0, 8'($urandom)};
                3:       raddr = A_LED | 32'($urandom_range(0, 3));
                4:       raddr = A_CYCLE;
                5, 6, 7: raddr = A_OUT | 32'($urandom_range(0, 3));
                8:       raddr = A_STATUS;
                default: raddr = A_IDLE | ($urandom & 32'h3FFF_FFFF);
            endcase
            step(1'($urandom_range(0, 1)), raddr, $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter RAM_WORDS, default 64, number of 32-bit data RAM words.
REQ-002 Parameter FIFO_DEPTH, default 4, number of output FIFO entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 MemWrite  input  1  processor store strobe, sampled on the clk edge.
REQ-006 Addr  input  32  processor byte address (processor ALUResult).
REQ-007 WriteData  input  32  store data.
REQ-008 ReadData  output  32  load data, combinational from Addr.
REQ-009 leds  output  8  LED register value.
REQ-010 out_data  output  32  FIFO head word.
REQ-011 out_valid  output  1  FIFO non-empty.
REQ-012 out_ready  input  1  external consumer accepts head.

Function
REQ-013 Address map SHALL be: RAM at Addr[31:8]==0 (word index Addr[7:2]); LED 0x8000_0000; CYCLE 0x8000_0004; OUT 0x8000_0008; STATUS 0x8000_000C; Addr[1:0] ignored.
REQ-014 RAM read SHALL be combinational; RAM write SHALL occur on the clk edge when MemWrite=1, visible to ReadData the following cycle.
REQ-015 LED: write stores WriteData[7:0]; read returns {24'b0, leds}.
REQ-016 CYCLE: 32-bit counter increments every non-reset cycle, wraps 0xFFFF_FFFF->0; read returns current registered value; writes ignored.
REQ-017 OUT: write with MemWrite=1 pushes WriteData into FIFO; read returns 0.
REQ-018 STATUS read SHALL return bit0 empty, bit1 full, bits[4:2] count (0..4), bit8 sticky overflow, all other bits 0.
REQ-019 STATUS write with WriteData[8]=1 SHALL clear overflow; other bits ignored.
REQ-020 Unmapped addresses SHALL read 0 and ignore writes.
REQ-021 out_valid SHALL equal not-empty; out_data SHALL equal head entry (0 when empty).
REQ-022 Pop SHALL occur on the edge where out_valid=1 and out_ready=1.
REQ-023 Push latency: word pushed into empty FIFO SHALL appear on out_data/out_valid the next cycle.
REQ-024 Push while full without pop SHALL drop the word and set overflow; FIFO contents unchanged.
REQ-025 Push and pop same cycle while full SHALL accept the push; count stays FIFO_DEPTH; overflow unchanged.
REQ-026 Push while empty with out_ready=1 SHALL not pop; count becomes 1.
REQ-027 Simultaneous overflow-set and STATUS clear impossible (single port); pointers wrap modulo FIFO_DEPTH.

Reset
REQ-028 Reset SHALL have priority over MemWrite and pop.
REQ-029 On reset: leds=0, CYCLE=0, FIFO empty (out_valid=0, out_data=0), overflow=0; RAM contents SHALL NOT be cleared.
REQ-030 Reset asserted mid-stream SHALL discard all queued FIFO words.

Structure
REQ-031 Shared package SHALL hold address constants, FIFO_DEPTH default, STATUS bit positions.
REQ-032 FIFO SHALL be a sub-module named out_fifo (push/full, pop/empty, count, data).
REQ-033 Address decode and read mux SHALL be combinational in the top of this block.

Verification
REQ-034 Store 0xDEADBEEF to 0x0000_0010, load 0x0000_0010 next cycle -> ReadData=0xDEADBEEF; load 0x0000_0014 unchanged.
REQ-035 Store 0x1A5 to 0x8000_0000 -> leds=0xA5, load LED -> 0x0000_00A5.
REQ-036 Release reset, load CYCLE after 10 cycles -> 10; force counter 0xFFFF_FFFF -> next 0.
REQ-037 out_ready=0, push 1,2,3,4,5 to OUT -> STATUS=0x0000_0112 (full, count 4, overflow); drain -> out_data 1,2,3,4, then out_valid=0.
REQ-038 FIFO full, push 9 with out_ready=1 same cycle -> pop head, 9 accepted, count 4, overflow unchanged; STATUS write 0x100 -> overflow=0.
REQ-039 Push 2 words, assert reset one cycle -> out_valid=0, STATUS=0x0000_0001, RAM word previously stored still reads back.
